// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              re;
  logic              we;
  logic [DATA_W-1:0] wrt_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_ack;
  logic              busy;
  logic              err;

  modport master (
    output addr, re, we, wrt_data,
    input  rd_data, rd_valid, wr_ack, busy, err
  );

  modport slave (
    input  addr, re, we, wrt_data,
    output rd_data, rd_valid, wr_ack, busy, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory answering one load/store at a time after RD_LATENCY/WR_LATENCY edges.
// busy holds the MEM stage while a request is in flight; DMEM_INIT_EN adds a post-reset zero-fill pass.
module dmem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus
);
  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

`ifdef DMEM_INIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2, INIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RD_WAIT = 2'd1, WR_WAIT = 2'd2} state_t;
`endif

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [DEPTH_LOG2-1:0]   addr_q;
  logic                    oor_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic                    rd_valid_q;
  logic                    wr_ack_q;
  logic                    err_q;

  logic [DATA_W-1:0]       mem [DEPTH];
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [DATA_W-1:0]       mem_wdata;

  logic                    req_ok;
  logic                    accept_rd;
  logic                    accept_wr;
  logic                    both_req;
  logic                    rd_done;
  logic                    wr_done;

`ifdef DMEM_INIT_EN
  logic [DEPTH_LOG2-1:0]   init_q;
  logic                    init_pending_q;

  // The clear pass starts on the first edge after reset so busy reads 0 while rst is held.
  assign req_ok = (state_q == IDLE) && !init_pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_q         <= '0;
      init_pending_q <= 1'b1;
    end else begin
      if (state_q == IDLE) begin
        init_pending_q <= 1'b0;
      end
      if (state_q == INIT) begin
        init_q <= init_q + 1'b1;
      end
    end
  end
`else
  assign req_ok = (state_q == IDLE);
`endif

  assign accept_rd = req_ok && bus.re && !bus.we;
  assign accept_wr = req_ok && bus.we && !bus.re;
  assign both_req  = req_ok && bus.re && bus.we;
  assign rd_done   = (state_q == RD_WAIT) && (cnt_q == '0);
  assign wr_done   = (state_q == WR_WAIT) && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = wdata_q;
    case (state_q)
      IDLE: begin
`ifdef DMEM_INIT_EN
        if (init_pending_q) begin
          state_d = INIT;
        end else
`endif
        if (accept_rd) begin
          state_d = RD_WAIT;
        end else if (accept_wr) begin
          state_d = WR_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          // Out-of-range stores are acknowledged but must not alias onto a real word.
          mem_we  = !oor_q;
        end
      end
`ifdef DMEM_INIT_EN
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = init_q;
        mem_wdata = '0;
        if (&init_q) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      addr_q     <= '0;
      oor_q      <= 1'b0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_ack_q   <= 1'b0;
      err_q      <= 1'b0;

      if (accept_rd || accept_wr) begin
        cnt_q   <= accept_rd ? CNT_W'(RD_LATENCY - 1) : CNT_W'(WR_LATENCY - 1);
        addr_q  <= bus.addr[DEPTH_LOG2-1:0];
        oor_q   <= |bus.addr[ADDR_W-1:DEPTH_LOG2];
        wdata_q <= bus.wrt_data;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (both_req) begin
        err_q <= 1'b1;
      end

      if (rd_done) begin
        rd_data_q  <= oor_q ? '0 : mem[addr_q];
        rd_valid_q <= 1'b1;
        err_q      <= oor_q;
      end

      if (wr_done) begin
        wr_ack_q <= 1'b1;
        err_q    <= oor_q;
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.wr_ack   = wr_ack_q;
  assign bus.err      = err_q;
  assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases then random traffic against an array model of memory.
module tb_dmem_responder;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] model   [1024];
  bit          written [1024];

  dmem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dmem_responder #(
    .ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(10),
    .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Noise on the request lines while busy; the responder must ignore all of it.
  task automatic junk();
    bus.addr     = 16'($urandom);
    bus.wrt_data = 16'($urandom);
    bus.re       = 1'($urandom_range(0, 1));
    bus.we       = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_inputs();
    bus.re = 1'b0;
    bus.we = 1'b0;
  endtask

  // Called on a negedge; the request is presented for the next rising edge.
  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    int n;
    int busy_n;
    bit oor;
    oor = (a[15:10] != 6'd0);
    bus.addr = a; bus.wrt_data = d; bus.we = 1'b1; bus.re = 1'b0;
    n = 0; busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) begin
        busy_n++;
        junk();
      end
    end while (!bus.wr_ack && n < 20);
    idle_inputs();
    chk("wr_latency", n - 1, WR_LAT);
    chk("wr_busy_cycles", busy_n, WR_LAT);
    chk("wr_err", bus.err, oor);
    chk("wr_no_rd_valid", bus.rd_valid, 1'b0);
    if (!oor) begin
      model[a[9:0]]   = d;
      written[a[9:0]] = 1'b1;
    end
  endtask

  task automatic do_read(input logic [15:0] a);
    int n;
    int busy_n;
    bit oor;
    oor = (a[15:10] != 6'd0);
    bus.addr = a; bus.re = 1'b1; bus.we = 1'b0;
    n = 0; busy_n = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.busy) begin
        busy_n++;
        junk();
      end
    end while (!bus.rd_valid && n < 20);
    idle_inputs();
    chk("rd_latency", n - 1, RD_LAT);
    chk("rd_busy_cycles", busy_n, RD_LAT);
    chk("rd_err", bus.err, oor);
    chk("rd_no_wr_ack", bus.wr_ack, 1'b0);
    if (oor) begin
      chk("rd_data_oor", bus.rd_data, 16'h0000);
    end else if (written[a[9:0]]) begin
      chk("rd_data", bus.rd_data, model[a[9:0]]);
    end
  endtask

  task automatic do_both(input logic [15:0] a);
    bus.addr = a; bus.re = 1'b1; bus.we = 1'b1; bus.wrt_data = 16'($urandom);
    @(negedge clk);
    idle_inputs();
    chk("both_err", bus.err, 1'b1);
    chk("both_busy", bus.busy, 1'b0);
    chk("both_no_pulse", {bus.rd_valid, bus.wr_ack}, 2'b00);
    @(negedge clk);
    chk("both_err_drop", bus.err, 1'b0);
  endtask

  task automatic gap();
    idle_inputs();
    @(negedge clk);
    chk("pulse_drop", {bus.rd_valid, bus.wr_ack, bus.err, bus.busy}, 4'b0000);
  endtask

  initial begin
    logic [15:0] a;
    int          op;
    int          busy_n;

    rst = 1'b1;
    bus.addr = '0; bus.wrt_data = '0; bus.re = 1'b0; bus.we = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      written[i] = 1'b0;
      model[i]   = '0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.rd_data, bus.rd_valid, bus.wr_ack, bus.err, bus.busy}, 20'h0);
    rst = 1'b0;

`ifdef DMEM_INIT_EN
    busy_n = 0;
    bus.addr = 16'h0003; bus.re = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (i == 10) idle_inputs();
      if (bus.busy) busy_n++;
      chk("init_no_rd_valid", bus.rd_valid, 1'b0);
    end
    chk("init_busy_cycles", busy_n, 1024);
    for (int i = 0; i < 1024; i++) begin
      written[i] = 1'b1;
    end
    do_read(16'h0003);
    do_read(16'h03FF);
`else
    @(negedge clk);
`endif

    // Basic write then read
    do_write(16'h0005, 16'hBEEF);
    gap();
    do_read(16'h0005);
    gap();

    // Back-to-back: read presented while wr_ack is high
    do_write(16'h0010, 16'h1234);
    do_read(16'h0010);
    gap();

    // Both requests at once: error only, array untouched
    do_both(16'h0010);
    do_read(16'h0010);
    gap();

    // Out-of-range read and write
    do_write(16'h0000, 16'h1111);
    do_read(16'h0400);
    do_write(16'h0400, 16'hFFFF);
    do_read(16'h0000);
    gap();

    // Reset while a write is pending
    do_write(16'h0020, 16'h5555);
    gap();
    bus.addr = 16'h0020; bus.wrt_data = 16'hAAAA; bus.we = 1'b1;
    @(negedge clk);
    chk("pending_busy", bus.busy, 1'b1);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("midreq_reset_outputs", {bus.rd_data, bus.rd_valid, bus.wr_ack, bus.err, bus.busy}, 20'h0);
    @(negedge clk);
    rst = 1'b0;
`ifdef DMEM_INIT_EN
    busy_n = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
    end
    chk("reinit_busy_cycles", busy_n, 1024);
    for (int i = 0; i < 1024; i++) begin
      model[i] = '0;
    end
`endif
    do_read(16'h0020);
    gap();

    // Random traffic over a small window with occasional out-of-range addresses
    for (int k = 0; k < 80; k++) begin
      a = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a | 16'h0400 | 16'(($urandom_range(0, 63)) << 10);
      op = $urandom_range(0, 9);
      if (op < 4)       do_write(a, 16'($urandom));
      else if (op < 8)  do_read(a);
      else if (op == 8) do_both(a);
      else              gap();
    end
    gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
